uart_transmitter: RTL and testbench

//  Serialises one byte per handshake into an asynchronous UART frame on Tx.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_counter.sv | 30 +++
 rtl/uart_transmitter.sv | 132 +++++++++++++
 tb/tb_uart_transmitter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter (and the matching receiver).
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic uart_even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CYCLES_PER_BIT-1 and flags the last cycle of
// each bit. Held at zero while clear is asserted.
module uart_baud_counter #(
  parameter int unsigned CYCLES_PER_BIT = 4
) (
  input  logic clk,
  input  logic nRst,
  input  logic clear,
  output logic bit_end
);

  localparam logic [15:0] LAST = 16'(CYCLES_PER_BIT - 1);

  logic [15:0] cnt_q, cnt_d;

  assign bit_end = ~clear & (cnt_q == LAST);

  // Next count: wrap on the last cycle of a bit, zero while cleared.
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clear || (cnt_q == LAST)) cnt_d = '0;
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!nRst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: one byte per valid/ready handshake, sent as
// start(0), 8 data bits LSB first, optional even parity, stop(1).
// Define UART_TX_PARITY_EN for an 8E1 frame; otherwise the frame is 8N1.
// Tx is registered from the next-state value, so it changes the cycle after
// the decision that drives it (e.g. Tx falls the cycle after accept).
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE      = 9600,
  parameter int unsigned CLOCK_FREQ     = 50000000,
  parameter int unsigned CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       enable,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       Tx,
  output logic       busy,
  output logic       tx_done
);

  uart_tx_state_t              state_q, state_d;
  logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
  logic [2:0]                  idx_q, idx_d;
  logic                        tx_q, tx_d;
  logic                        done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                        par_q, par_d;
`endif
  logic                        bit_end;
  logic                        accept;
  logic                        clear;

  assign data_ready = enable & (state_q == IDLE);
  assign accept     = data_valid & data_ready;
  assign busy       = (state_q != IDLE);
  assign Tx         = tx_q;
  assign tx_done    = done_q;
  // Counter idles at zero so the first START cycle is count 0; an abort also
  // zeroes it so a following frame starts clean.
  assign clear      = (state_q == IDLE) | ~enable;

  uart_baud_counter #(.CYCLES_PER_BIT(CYCLES_PER_BIT)) u_baud (
    .clk     (clk),
    .nRst    (nRst),
    .clear   (clear),
    .bit_end (bit_end)
  );

  // Next-state, datapath and registered-Tx source.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: if (accept) begin
        shift_d = data_in;
        idx_d   = '0;
`ifdef UART_TX_PARITY_EN
        par_d   = uart_even_parity(data_in);
`endif
        state_d = START;
      end
      START: if (bit_end) begin
        idx_d   = '0;
        state_d = DATA;
      end
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        idx_d   = idx_q + 3'd1;
        if (idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: if (bit_end) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Disable aborts immediately: byte dropped, no completion pulse.
    if (!enable) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter (CYCLES_PER_BIT = 4).
// A frame-level model (bit array indexed by cycles-since-accept) is compared
// against the DUT every cycle; literal frames pin the model.
module tb_uart_transmitter;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [10:0] LIT_A5 = 11'b10101001010;
  localparam logic [10:0] LIT_01 = 11'b11000000010;
`else
  localparam int NB = 10;
  localparam logic [10:0] LIT_A5 = 11'b01101001010;
  localparam logic [10:0] LIT_01 = 11'b01000000010;
`endif

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       enable = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready, Tx, busy, tx_done;

  uart_transmitter #(.BAUD_RATE(100), .CLOCK_FREQ(400)) dut (
    .clk        (clk),
    .nRst       (nRst),
    .enable     (enable),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .Tx         (Tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  bit          m_act = 0;
  int          m_k = 0;
  logic [10:0] m_frame = '1;
  logic        m_done = 0;
  bit          chk_on = 0;

  function automatic logic [10:0] build_frame(input logic [7:0] d);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^d;
`endif
    return f;
  endfunction

  always @(posedge clk) begin
    m_done = 1'b0;
    if (!nRst) begin
      m_act  = 0;
      chk_on = 1;
    end else if (m_act) begin
      if (!enable) m_act = 0;
      else begin
        m_k++;
        if (m_k == NB * CPB) begin
          m_act  = 0;
          m_done = 1'b1;
        end
      end
    end else if (enable && data_valid) begin
      m_frame = build_frame(data_in);
      m_k     = 0;
      m_act   = 1;
    end
    #1;
    if (chk_on) begin
      chk("tx",      Tx,         m_act ? m_frame[m_k / CPB] : 1'b1);
      chk("busy",    busy,       m_act);
      chk("done",    tx_done,    m_done);
      chk("ready",   data_ready, enable & ~m_act);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic cap_tx  [0:63];
  logic cap_dn  [0:63];
  logic cap_rdy [0:63];

  // Offer byte b, wait (bounded) for accept, capture ncap cycles from accept.
  // hold: keep data_valid high and present nxt as the next byte.
  task automatic send(input logic [7:0] b, input int ncap, input bit scramble,
                      input bit hold, input logic [7:0] nxt);
    bit ok;
    @(negedge clk);
    data_in = b; data_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (data_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: data_ready still %b, required 1", data_ready);
      data_valid = 1'b0;
      return;
    end
    @(posedge clk); #2;
    cap_tx[0] = Tx; cap_dn[0] = tx_done; cap_rdy[0] = data_ready;
    @(negedge clk);
    if (hold) data_in = nxt;
    else begin
      data_valid = 1'b0;
      if (scramble) data_in = ~b;
    end
    for (int i = 1; i < ncap; i++) begin
      @(posedge clk); #2;
      cap_tx[i] = Tx; cap_dn[i] = tx_done; cap_rdy[i] = data_ready;
    end
  endtask

  task automatic check_frame(input string name, input logic [10:0] lit);
    for (int b = 0; b < NB; b++)
      chk($sformatf("%s_bit%0d", name, b), cap_tx[b * CPB + 1], lit[b]);
    chk({name, "_done_early"}, cap_dn[NB * CPB - 1], 1'b0);
    chk({name, "_done"},       cap_dn[NB * CPB],     1'b1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    checks++; errors++;
    $display("FAIL idle_timeout: busy=%b, required 0", busy);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Reset held three cycles.
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tx",    Tx,         1'b1);
    chk("rst_busy",  busy,       1'b0);
    chk("rst_ready", data_ready, 1'b1);
    chk("rst_done",  tx_done,    1'b0);
    @(negedge clk) nRst = 1'b1;

    // Known frames, data_in changed after accept.
    send(8'hA5, NB * CPB + 1, 1, 0, 8'h00);
    check_frame("a5", LIT_A5);
    wait_idle();
    send(8'h01, NB * CPB + 1, 1, 0, 8'h00);
    check_frame("x01", LIT_01);
    wait_idle();

    // Back-to-back with data_valid held high.
    send(8'h3C, NB * CPB + 2, 0, 1, 8'hC3);
    @(negedge clk) data_valid = 1'b0;
    chk("b2b_ready_busy", cap_rdy[5],            1'b0);
    chk("b2b_gap_high",   cap_tx[NB * CPB],      1'b1);
    chk("b2b_gap_ready",  cap_rdy[NB * CPB],     1'b1);
    chk("b2b_second_start", cap_tx[NB * CPB + 1], 1'b0);
    wait_idle();

    // Abort during data bit 3.
    send(8'h5A, 4 * CPB + 2, 0, 0, 8'h00);
    @(negedge clk) enable = 1'b0;
    @(posedge clk); #2;
    chk("abort_tx",   Tx,      1'b1);
    chk("abort_busy", busy,    1'b0);
    chk("abort_done", tx_done, 1'b0);
    @(negedge clk) enable = 1'b1;
    send(8'hA5, NB * CPB + 1, 0, 0, 8'h00);
    check_frame("after_abort", LIT_A5);
    wait_idle();

    // Reset during the parity bit (stop bit in 8N1).
    send(8'hF0, 9 * CPB + 2, 0, 0, 8'h00);
    @(negedge clk) nRst = 1'b0;
    @(posedge clk); #2;
    chk("midrst_tx",   Tx,   1'b1);
    chk("midrst_busy", busy, 1'b0);
    @(negedge clk) nRst = 1'b1;

    // Randomized traffic with aborts, resets and disabled offers.
    for (int it = 0; it < 40; it++) begin
      send(8'($urandom), $urandom_range(1, NB * CPB + 1), 1'($urandom), 0, 8'h00);
      case ($urandom_range(0, 9))
        0: begin @(negedge clk) enable = 1'b0; @(negedge clk) enable = 1'b1; end
        1: begin @(negedge clk) nRst = 1'b0;   @(negedge clk) nRst = 1'b1;   end
        2: begin
          @(negedge clk); enable = 1'b0; data_valid = 1'b1; data_in = 8'($urandom);
          repeat (2) @(negedge clk);
          data_valid = 1'b0; enable = 1'b1;
        end
        default: repeat ($urandom_range(0, 3)) @(negedge clk) data_in = 8'($urandom);
      endcase
    end
    wait_idle();
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
